// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, imem request handshake,
// single-entry instruction hold and misaligned-redirect fault trap.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    output logic        misalign_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        err_q;
    logic [31:0] pc_plus4;
    logic        consume;
    logic        tgt_aligned;

    assign pc_plus4    = pc_q + 32'd4;
    assign consume     = (state == HOLD) && !stall;
    assign tgt_aligned = (PCTarget[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (consume) begin
                        valid_q <= 1'b0;
                        if (!PCSrc) begin
                            pc_q  <= pc_plus4;
                            state <= FETCH;
                        end else if (tgt_aligned) begin
                            pc_q  <= PCTarget;
                            state <= FETCH;
                        end else begin
                            err_q <= 1'b1;
                            state <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    // Unreachable encoding: trap rather than fetch garbage
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                    state   <= FAULT;
                end
            endcase
        end
    end

    // Request drops the instant reset rises so an in-flight fetch is abandoned
    assign imem_req     = (state == FETCH) && !rst;
    assign imem_addr    = pc_q;
    assign Instr        = instr_q;
    assign PC           = pc_q;
    assign PCPlus4      = pc_plus4;
    assign instr_valid  = valid_q;
    assign misalign_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetches, stalls,
// redirects, wrap, mid-wait reset and misaligned-redirect fault.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        misalign_err;

    int tests = 0;
    int fails = 0;

    logic [63:0] sb[$];
    logic        prev_v = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .PCSrc(PCSrc),
        .PCTarget(PCTarget),
        .stall(stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack(imem_ack),
        .Instr(Instr),
        .PC(PC),
        .PCPlus4(PCPlus4),
        .instr_valid(instr_valid),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each new valid instruction must match the scoreboard head
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && prev_v !== 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h expected none",
                         PC, Instr);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("sb_pc", PC, e[63:32]);
                chk("sb_instr", Instr, e[31:0]);
            end
        end
        prev_v = instr_valid;
    end

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int delay);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_req_seen", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, addr);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        sb.push_back({addr, data});
        exp_pc    = addr;
        exp_instr = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hA5A5_5A5A;
        chk("hold_req", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic consume(input int stalls, input logic src,
                           input logic [31:0] tgt);
        for (int i = 0; i < stalls; i++) begin
            stall    = 1'b1;
            PCSrc    = 1'b1;
            PCTarget = 32'h0000_0200;
            imem_ack = 1'b1;
            @(negedge clk);
            imem_ack = 1'b0;
            chk("stall_pc", PC, exp_pc);
            chk("stall_instr", Instr, exp_instr);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        stall    = 1'b0;
        PCSrc    = src;
        PCTarget = tgt;
        @(negedge clk);
        PCSrc    = 1'b0;
        PCTarget = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        PCSrc      = 1'b0;
        PCTarget   = 32'h0;
        stall      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);

        // zero-wait fetch, sequential consume
        do_fetch(32'h0, 32'h0050_0093, 0);
        chk("plus4_0", PCPlus4, 32'h4);
        consume(0, 1'b0, 32'h0);
        // 3-cycle ack delay, 4-cycle stall with PCSrc held high
        do_fetch(32'h4, 32'h00A0_0113, 3);
        consume(4, 1'b0, 32'h0);
        // aligned redirect
        do_fetch(32'h8, 32'h0020_81B3, 1);
        consume(0, 1'b1, 32'h0000_0100);

        // reset while a fetch is waiting; late ack arrives during reset
        chk("mid_addr", imem_addr, 32'h100);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", PC, 32'h0);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        rst      = 1'b0;
        #1;
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, 32'h0);
        @(negedge clk);
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("stale_instr", Instr, 32'h0000_0013);

        // wrap at top of address space
        do_fetch(32'h0, 32'h0000_0013, 0);
        consume(0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_plus4", PCPlus4, 32'h0);
        do_fetch(32'hFFFF_FFFC, 32'h1234_5678, 0);
        consume(0, 1'b0, 32'h0);

        // misaligned redirect enters terminal fault
        do_fetch(32'h0, 32'h0000_0063, 0);
        consume(0, 1'b1, 32'h0000_0102);
        chk("fault_err", {31'd0, misalign_err}, 32'd1);
        chk("fault_req", {31'd0, imem_req}, 32'd0);
        chk("fault_valid", {31'd0, instr_valid}, 32'd0);
        chk("fault_pc", PC, 32'h0);
        for (int i = 0; i < 5; i++) begin
            imem_ack = 1'b1;
            stall    = i[0];
            PCSrc    = 1'b1;
            PCTarget = 32'h0000_0100;
            @(negedge clk);
            chk("fault_hold_err", {31'd0, misalign_err}, 32'd1);
            chk("fault_hold_req", {31'd0, imem_req}, 32'd0);
            chk("fault_hold_pc", PC, 32'h0);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
        PCSrc    = 1'b0;
        rst      = 1'b1;
        #1;
        chk("fault_clr_err", {31'd0, misalign_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("fault_clr_req", {31'd0, imem_req}, 32'd1);
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port PCSrc, input, 1 bit: redirect select (Branch AND Zero from the execute path).
REQ-005 SHALL have port PCTarget, input, 32 bits: redirect target address.
REQ-006 SHALL have port stall, input, 1 bit: downstream not ready; the held instruction is not consumed.
REQ-007 SHALL have port imem_req, output, 1 bit: instruction memory read request.
REQ-008 SHALL have port imem_addr, output, 32 bits: read address, always equal to PC.
REQ-009 SHALL have port imem_rdata, input, 32 bits: read data, valid only when imem_ack=1.
REQ-010 SHALL have port imem_ack, input, 1 bit: read complete, single-cycle pulse.
REQ-011 SHALL have port Instr, output, 32 bits: fetched instruction to the main decoder; opcode is Instr[6:0].
REQ-012 SHALL have port PC, output, 32 bits: address of the instruction currently in Instr.
REQ-013 SHALL have port PCPlus4, output, 32 bits: PC+4, combinational, modulo 2^32.
REQ-014 SHALL have port instr_valid, output, 1 bit: Instr and PC are valid for the decoder.
REQ-015 SHALL have port misalign_err, output, 1 bit: sticky fault flag for a misaligned redirect.

Function
REQ-016 SHALL implement a three-state FSM with states FETCH, HOLD and FAULT.
REQ-017 SHALL, in FETCH, drive imem_req=1 and imem_addr=PC, held stable until imem_ack, with unlimited wait cycles.
REQ-018 SHALL, on imem_ack=1 in FETCH, register imem_rdata into Instr and enter HOLD; instr_valid=1 from the next cycle (1-cycle latency).
REQ-019 SHALL, in HOLD, drive imem_req=0 and instr_valid=1, keeping Instr and PC unchanged.
REQ-020 SHALL, in HOLD with stall=1, hold all state; PCSrc and PCTarget are ignored.
REQ-021 SHALL, in HOLD with stall=0, treat the instruction as consumed that cycle and apply REQ-022 to REQ-024.
REQ-022 SHALL, on consume with PCSrc=0, load PC<=PC+4 (wrap 32'hFFFF_FFFC -> 32'h0) and enter FETCH.
REQ-023 SHALL, on consume with PCSrc=1 and PCTarget[1:0]==2'b00, load PC<=PCTarget and enter FETCH.
REQ-024 SHALL, on consume with PCSrc=1 and PCTarget[1:0]!=2'b00, leave PC unchanged, set misalign_err=1 and enter FAULT.
REQ-025 SHALL, in FETCH, clear instr_valid to 0; Instr retains its last value.
REQ-026 SHALL ignore imem_ack outside FETCH.
REQ-027 SHALL treat FAULT as terminal until rst: imem_req=0, instr_valid=0, misalign_err=1, and all inputs ignored.
REQ-028 SHALL sustain a best-case throughput of one instruction per 2 cycles (ack in the request cycle, stall=0).

Reset
REQ-029 SHALL, on rst=1, immediately and asynchronously set PC=RESET_PC, Instr=32'h0000_0013 (NOP), instr_valid=0, misalign_err=0 and state=FETCH.
REQ-030 SHALL hold imem_req=0 while rst=1 and assert it in the first cycle after rst deasserts.
REQ-031 SHALL abandon any fetch outstanding when rst asserts; the memory is required to abort it, and no stale ack is accepted.

Verification
REQ-032 SHALL cover reset then zero-wait memory with stall=0: ack in cycle 1 -> instr_valid=1 in cycle 2 with PC=0; the next imem_addr is 32'h4 in cycle 3.
REQ-033 SHALL cover a 3-cycle ack delay: imem_addr stays 32'h0 and imem_req stays 1 for 3 cycles; Instr equals the acked data exactly.
REQ-034 SHALL cover stall=1 for 4 cycles in HOLD while PCSrc=1: PC, Instr and instr_valid are unchanged; after stall=0 with PCSrc=0, the next imem_addr is PC+4.
REQ-035 SHALL cover a redirect with PCSrc=1 and PCTarget=32'h0000_0100 on consume: the next imem_addr is 32'h100.
REQ-036 SHALL cover a misaligned redirect with PCSrc=1 and PCTarget=32'h0000_0102 on consume: misalign_err=1 and imem_req=0 permanently, cleared only by rst.
REQ-037 SHALL cover PC=32'hFFFF_FFFC consumed with PCSrc=0: the next imem_addr is 32'h0 and PCPlus4 wraps; also cover rst asserted mid-wait, after which a late ack is ignored and refetch starts at RESET_PC.
